// File: rtl/dlpf_mac_scheduler_pkg.sv
// Shared types and Q-format helpers for the time-multiplexed biquad low-pass scheduler.
package dlpf_pkg;

    // Scheduler sequencing states.
    typedef enum logic [1:0] {
        ST_ARB = 2'd0,
        ST_MAC = 2'd1,
        ST_WB  = 2'd2,
        ST_OUT = 2'd3
    } state_e;

    // Coefficient bank slots, also the write address map.
    typedef enum logic [2:0] {
        COEF_B0 = 3'd0,
        COEF_B1 = 3'd1,
        COEF_B2 = 3'd2,
        COEF_A1 = 3'd3,
        COEF_A2 = 3'd4
    } coef_idx_e;

    localparam int NUM_COEF = 5;
    localparam int NUM_TAPS = 5;

    // Coefficients are Q2.(cw-2): that many fractional bits.
    function automatic int q_frac_bits(input int cw);
        return cw - 2;
    endfunction

    // Half an output LSB in accumulator units, for round-half-up.
    function automatic longint q_round_const(input int cw);
        return longint'(1) << (cw - 3);
    endfunction

    // b0 = 1.0 and everything else 0 gives a pass-through filter.
    function automatic int default_coef(input int idx, input int cw);
        return (idx == int'(COEF_B0)) ? (1 << (cw - 2)) : 0;
    endfunction

endpackage

// File: rtl/dlpf_mac_scheduler_if.sv
// Sample-in, coefficient-write and result-out bundle of the filter scheduler.
interface dlpf_mac_scheduler_if #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int CW  = 16
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]        in_valid;
    logic [NCH*DW-1:0]     in_data;
    logic [NCH-1:0]        in_ready;
    logic                  coef_we;
    logic [2:0]            coef_addr;
    logic signed [CW-1:0]  coef_data;
    logic                  coef_err;
    logic                  out_valid;
    logic                  out_ready;
    logic [CHW-1:0]        out_ch;
    logic signed [DW-1:0]  out_data;
    logic                  busy;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, coef_err, out_valid, out_ch, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, coef_err, out_valid, out_ch, out_data, busy
    );
endinterface

// File: rtl/dlpf_mac_scheduler_mac.sv
// Shared signed multiply-accumulate: one product per enabled cycle.
module dlpf_mac #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int ACCW = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   sub,
    input  logic signed [DW-1:0]   a,
    input  logic signed [CW-1:0]   b,
    output logic signed [ACCW-1:0] acc
);
    logic signed [DW+CW-1:0] prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  acc_base;
    logic signed [ACCW-1:0]  acc_reg;
    logic signed [ACCW-1:0]  acc_next;

    assign prod     = a * b;
    assign prod_ext = $signed({{(ACCW-DW-CW){prod[DW+CW-1]}}, prod});

    // Clear restarts the sum from this product; sub negates the feedback taps.
    always_comb begin
        acc_base = clr ? '0 : acc_reg;
        acc_next = sub ? (acc_base - prod_ext) : (acc_base + prod_ext);
    end

    // Accumulator register, only advanced while the scheduler is in MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;
endmodule

// File: rtl/dlpf_mac_scheduler.sv
// Round-robin scheduler sharing one MAC across NCH biquad low-pass channels.
module dlpf_mac_scheduler #(
    parameter int NCH  = 4,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int ACCW = 40
) (
    input logic                clk,
    input logic                rst,
    dlpf_mac_scheduler_if.slave bus
);
    import dlpf_pkg::*;

    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FRAC = q_frac_bits(CW);
    localparam logic signed [ACCW-1:0] RND_CONST = ACCW'(q_round_const(CW));
    localparam logic signed [ACCW-1:0] SAT_MAX   = ACCW'((longint'(1) << (DW-1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN   = ACCW'(-(longint'(1) << (DW-1)));

    state_e                 state_reg, state_next;
    logic [2:0]             tap_reg;
    logic [CHW-1:0]         grant_reg, rr_ptr_reg, arb_idx;
    logic                   arb_found, grant_fire, coef_accept;
    logic signed [DW-1:0]   x_cur_reg;
    logic signed [DW-1:0]   x1_reg [NCH];
    logic signed [DW-1:0]   x2_reg [NCH];
    logic signed [DW-1:0]   y1_reg [NCH];
    logic signed [DW-1:0]   y2_reg [NCH];
    logic signed [CW-1:0]   coef_reg [NUM_COEF];
    logic                   coef_err_reg;
    logic signed [DW-1:0]   out_data_reg;
    logic [CHW-1:0]         out_ch_reg;
    logic signed [DW-1:0]   mac_a;
    logic signed [CW-1:0]   mac_b;
    logic signed [ACCW-1:0] acc, rnd_sum, rnd_shift;
    logic signed [DW-1:0]   r_sat;

    // Search for the first requester starting at rr_ptr, wrapping modulo NCH.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            int idx;
            idx = (int'(rr_ptr_reg) + i) % NCH;
            if (!arb_found && bus.in_valid[idx]) begin
                arb_found = 1'b1;
                arb_idx   = CHW'(idx);
            end
        end
    end

    assign grant_fire  = (state_reg == ST_ARB) && arb_found;
    assign coef_accept = bus.coef_we && (state_reg == ST_ARB) && (bus.coef_addr <= 3'(NUM_COEF - 1));

    // One-hot grant, only ever visible while arbitrating.
    always_comb begin
        bus.in_ready = '0;
        if (grant_fire) begin
            bus.in_ready[arb_idx] = 1'b1;
        end
    end

    // Next-state logic for ARB -> MAC -> WB -> OUT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:  if (arb_found) state_next = ST_MAC;
            ST_MAC:  if (tap_reg == 3'(NUM_TAPS - 1)) state_next = ST_WB;
            ST_WB:   state_next = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_next = ST_ARB;
            default: state_next = ST_ARB;
        endcase
    end

    // State, tap counter, grant latch and captured sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_ARB;
            tap_reg    <= '0;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            x_cur_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_fire) begin
                grant_reg  <= arb_idx;
                rr_ptr_reg <= (int'(arb_idx) == NCH - 1) ? '0 : arb_idx + 1'b1;
                x_cur_reg  <= bus.in_data[int'(arb_idx)*DW +: DW];
                tap_reg    <= '0;
            end else if (state_reg == ST_MAC) begin
                tap_reg <= tap_reg + 3'd1;
            end
        end
    end

    // Operand select per tap: feed-forward taps add, feedback taps subtract.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        case (tap_reg)
            3'd0: begin mac_a = x_cur_reg;           mac_b = coef_reg[int'(COEF_B0)]; end
            3'd1: begin mac_a = x1_reg[grant_reg];   mac_b = coef_reg[int'(COEF_B1)]; end
            3'd2: begin mac_a = x2_reg[grant_reg];   mac_b = coef_reg[int'(COEF_B2)]; end
            3'd3: begin mac_a = y1_reg[grant_reg];   mac_b = coef_reg[int'(COEF_A1)]; end
            3'd4: begin mac_a = y2_reg[grant_reg];   mac_b = coef_reg[int'(COEF_A2)]; end
            default: begin mac_a = '0; mac_b = '0; end
        endcase
    end

    dlpf_mac #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_mac (
        .clk (clk),
        .rst (rst),
        .en  (state_reg == ST_MAC),
        .clr (tap_reg == 3'd0),
        .sub (tap_reg >= 3'd3),
        .a   (mac_a),
        .b   (mac_b),
        .acc (acc)
    );

    // Round half-up back to sample scale, then clamp to the sample range.
    always_comb begin
        rnd_sum   = acc + RND_CONST;
        rnd_shift = rnd_sum >>> FRAC;
        if (rnd_shift > SAT_MAX) begin
            r_sat = DW'(SAT_MAX);
        end else if (rnd_shift < SAT_MIN) begin
            r_sat = DW'(SAT_MIN);
        end else begin
            r_sat = DW'(rnd_shift);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_hist
            // Per-channel delay line, shifted on write-back of that channel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    x1_reg[gi] <= '0;
                    x2_reg[gi] <= '0;
                    y1_reg[gi] <= '0;
                    y2_reg[gi] <= '0;
                end else if (state_reg == ST_WB && grant_reg == CHW'(gi)) begin
                    x2_reg[gi] <= x1_reg[gi];
                    x1_reg[gi] <= x_cur_reg;
                    y2_reg[gi] <= y1_reg[gi];
                    y1_reg[gi] <= r_sat;
                end
            end
        end

        for (gi = 0; gi < NUM_COEF; gi++) begin : g_coef
            // Coefficient slot, writable only while arbitrating.
            always_ff @(posedge clk) begin
                if (rst) begin
                    coef_reg[gi] <= CW'(default_coef(gi, CW));
                end else if (coef_accept && bus.coef_addr == 3'(gi)) begin
                    coef_reg[gi] <= bus.coef_data;
                end
            end
        end
    endgenerate

    // Flag a dropped coefficient write one cycle after it was attempted.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_err_reg <= 1'b0;
        end else begin
            coef_err_reg <= bus.coef_we && (state_reg != ST_ARB) &&
                            (bus.coef_addr <= 3'(NUM_COEF - 1));
        end
    end

    // Result holding register, stable for the whole OUT phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg <= '0;
            out_ch_reg   <= '0;
        end else if (state_reg == ST_WB) begin
            out_data_reg <= r_sat;
            out_ch_reg   <= grant_reg;
        end
    end

    assign bus.out_valid = (state_reg == ST_OUT);
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.coef_err  = coef_err_reg;
    assign bus.busy      = (state_reg != ST_ARB);
endmodule

// File: tb/tb_dlpf_mac_scheduler.sv
// Scoreboard bench for the filter scheduler against a difference-equation model.
module tb_dlpf_mac_scheduler;
    localparam int NCH  = 4;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int ACCW = 40;
    localparam longint ONE  = longint'(1) << (CW - 2);
    localparam longint HALF = longint'(1) << (CW - 3);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dlpf_mac_scheduler_if #(.NCH(NCH), .DW(DW), .CW(CW)) bus();

    dlpf_mac_scheduler #(.NCH(NCH), .DW(DW), .CW(CW), .ACCW(ACCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_coef [5];
    int   m_x1 [NCH];
    int   m_x2 [NCH];
    int   m_y1 [NCH];
    int   m_y2 [NCH];
    int   m_rr;
    bit   rand_ready_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_coef = '{int'(ONE), 0, 0, 0, 0};
        for (int c = 0; c < NCH; c++) begin
            m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
        end
        m_rr = 0;
    endfunction

    // y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, rounded half-up to an integer, clamped.
    function automatic int model_sample(input int ch, input int x);
        longint acc, q, r;
        acc = longint'(m_coef[0]) * x + longint'(m_coef[1]) * m_x1[ch]
            + longint'(m_coef[2]) * m_x2[ch] - longint'(m_coef[3]) * m_y1[ch]
            - longint'(m_coef[4]) * m_y2[ch];
        q = acc + HALF;
        if (q >= 0) r = q / ONE;
        else        r = -((-q + ONE - 1) / ONE);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        m_x2[ch] = m_x1[ch];
        m_x1[ch] = x;
        m_y2[ch] = m_y1[ch];
        m_y1[ch] = int'(r);
        return int'(r);
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_rr + i) % NCH;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic set_req(input int ch, input int d);
        bus.in_valid[ch] = 1'b1;
        bus.in_data[ch*DW +: DW] = DW'(d);
    endtask

    // Wait for the grant predicted by the round-robin model, then retire or refresh the request.
    task automatic wait_grant(input bit keep, input bit push);
        int pg, n, x;
        pg = model_pick();
        n  = 0;
        @(negedge clk);
        while (bus.in_ready == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready == '0) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        chk("in_ready", longint'(bus.in_ready), (pg >= 0) ? (longint'(1) << pg) : 0);
        if (pg < 0) return;
        x = int'($signed(bus.in_data[pg*DW +: DW]));
        $display("GRANT ch=%0d in=%0d", pg, x);
        if (push) exp_q.push_back('{ch: pg, data: model_sample(pg, x)});
        m_rr = (pg + 1) % NCH;
        @(posedge clk); #1;
        if (keep) bus.in_data[pg*DW +: DW] = DW'(rnd_sample());
        else      bus.in_valid[pg] = 1'b0;
    endtask

    // Coefficient write issued while idle; it must land without error.
    task automatic write_coef(input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'(addr);
        bus.coef_data = CW'(val);
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        m_coef[addr] = val;
        @(negedge clk);
        chk("coef_err_idle", bus.coef_err, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.busy || bus.out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compare every accepted result against the oldest prediction.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_ch", longint'(bus.out_ch), e.ch);
                chk("out_data", bus.out_data, e.data);
                $display("OUT ch=%0d data=%0d expect ch=%0d data=%0d", bus.out_ch, bus.out_data, e.ch, e.data);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready_en) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nv;
        exp_t hold;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ch", longint'(bus.out_ch), 0);
        chk("rst_coef_err", bus.coef_err, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        @(posedge clk); #1;

        // Pass-through with reset coefficients and latency.
        set_req(0, 1234);
        wait_grant(1'b0, 1'b1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_mac", bus.busy, 1);
        end while (!bus.out_valid && k < 20);
        chk("latency", k, 7);

        // FIR step response with 0.25 taps.
        wait_idle();
        write_coef(0, 'h1000);
        write_coef(1, 'h1000);
        write_coef(2, 'h1000);
        write_coef(3, 0);
        write_coef(4, 0);
        for (int s = 0; s < 3; s++) begin
            set_req(1, 4000);
            wait_grant(1'b0, 1'b1);
        end

        // All channels requesting: rotation from the pointer left by channel 1.
        wait_idle();
        for (int c = 0; c < NCH; c++) set_req(c, rnd_sample());
        for (int s = 0; s < 5; s++) wait_grant(1'b1, 1'b1);
        bus.in_valid = '0;

        // Saturation at both rails.
        wait_idle();
        write_coef(0, 'h7FFF);
        write_coef(1, 0);
        write_coef(2, 0);
        set_req(3, 32767);
        wait_grant(1'b0, 1'b1);
        set_req(3, -32768);
        wait_grant(1'b0, 1'b1);

        // Backpressure: held result, no grant, dropped coefficient write.
        wait_idle();
        bus.out_ready = 1'b0;
        set_req(0, 5000);
        wait_grant(1'b0, 1'b1);
        set_req(2, 777);
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("stall_out_valid", bus.out_valid, 1);
        hold = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.coef_we   = (i == 2);
            bus.coef_addr = 3'd0;
            bus.coef_data = 16'h1234;
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, hold.data);
            chk("stall_ch", longint'(bus.out_ch), hold.ch);
            chk("stall_no_grant", longint'(bus.in_ready), 0);
            if (i == 2) chk("coef_err_early", bus.coef_err, 0);
            if (i == 3) chk("coef_err_pulse", bus.coef_err, 1);
            if (i == 4) chk("coef_err_end", bus.coef_err, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_grant(1'b0, 1'b1);

        // Reset during tap 3 abandons the sample and clears history.
        wait_idle();
        set_req(1, 3000);
        wait_grant(1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        chk("abandoned_no_output", nv, 0);
        chk("abandoned_busy", bus.busy, 0);
        @(posedge clk); #1;
        write_coef(1, 'h2000);
        write_coef(3, 'h1000);
        set_req(1, -1500);
        wait_grant(1'b0, 1'b1);

        // Randomized traffic, coefficients and backpressure.
        wait_idle();
        write_coef(0, int'($urandom_range(0, 'h4000)) - 'h1000);
        write_coef(1, int'($urandom_range(0, 'h4000)) - 'h2000);
        write_coef(2, int'($urandom_range(0, 'h4000)) - 'h2000);
        write_coef(3, int'($urandom_range(0, 'h4000)) - 'h2000);
        write_coef(4, int'($urandom_range(0, 'h1000)));
        rand_ready_en = 1'b1;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!bus.in_valid[c] && $urandom_range(0, 1) == 1) set_req(c, rnd_sample());
            end
            if (bus.in_valid == '0) set_req(int'($urandom_range(0, NCH - 1)), rnd_sample());
            wait_grant(1'b0, 1'b1);
        end
        k = 0;
        while (bus.in_valid != '0 && k < 10) begin
            wait_grant(1'b0, 1'b1);
            k++;
        end
        rand_ready_en = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
